hex_counter_display: RTL

Parametrised up/down counter with prescaler, synchronous load and terminal-count flag.
Drives N active-low seven-segment digits showing the count in hexadecimal.
Generalises the fixed 6-bit two-digit counter/display: any width, direction control, enable, load, rate division, and registered glitch-free display outputs.
Sits between board switches/keys and the HEX displays in lab top levels.

---
 rtl/hex_disp_pkg.sv | 53 +++++
 rtl/hex7seg_decoder.sv | 14 +
 rtl/hex_counter_display.sv | 113 +++++++++++
 3 files changed

// File: rtl/hex_disp_pkg.sv
// Shared seven-segment types, glyph constants and nibble decode for the hex counter display.
package hex_disp_pkg;

  localparam int unsigned SEG_W = 7;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Hex glyph for one nibble
  function automatic seg_t nibble_to_seg(input logic [3:0] nib);
    seg_t s;
    s = SEG_BLANK;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational nibble to active-low seven-segment glyph.
module hex7seg_decoder
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg_c
);

  // Pure lookup; the parent registers the result
  always_comb begin
    seg_c = nibble_to_seg(nibble);
  end

endmodule

// File: rtl/hex_counter_display.sv
// Prescaled up/down counter with load, wrap flag and registered hex display.
// Optional build macro HEX_COUNTER_BLANK_LEAD_EN blanks leading-zero digits (digit 0 always shown).
module hex_counter_display
  import hex_disp_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic                               up_dn,
  input  logic                               load,
  input  logic [WIDTH-1:0]                   load_val,
  output logic [WIDTH-1:0]                   count,
  output logic                               tc,
  output logic [SEG_W*((WIDTH+3)/4)-1:0]     hex
);

  localparam int unsigned NDIG  = (WIDTH + 3) / 4;
  localparam int unsigned PAD_W = 4 * NDIG;
  localparam int unsigned HEX_W = SEG_W * NDIG;
  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc;
  logic             step_c;
  logic             wrap_c;
  logic [PAD_W-1:0] cnt_pad_c;
  seg_t             dig_c [NDIG];
  logic [HEX_W-1:0] hex_nxt_c;

  // Step fires on the last prescaler phase of an enabled cycle
  always_comb begin
    step_c = en && (psc == PSC_LAST);
    wrap_c = up_dn ? (count == '1) : (count == '0);
  end

  // Prescaler phase: cleared by load, frozen while disabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc <= '0;
    end else if (load) begin
      psc <= '0;
    end else if (en) begin
      psc <= step_c ? '0 : psc + PSC_W'(1);
    end
  end

  // Count register with wrap pulse registered alongside it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_val;
      tc    <= 1'b0;
    end else if (step_c) begin
      count <= up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
      tc    <= wrap_c;
    end else begin
      tc    <= 1'b0;
    end
  end

  // Zero-extend so the top digit always sees a full nibble
  always_comb begin
    cnt_pad_c = PAD_W'(count);
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    hex7seg_decoder u_dec (
      .nibble (cnt_pad_c[4*g +: 4]),
      .seg_c  (dig_c[g])
    );
  end

`ifdef HEX_COUNTER_BLANK_LEAD_EN
  logic [NDIG-1:0] blank_c;

  // A digit blanks when it and every more-significant nibble are zero
  for (genvar g = 0; g < NDIG; g++) begin : g_blank
    if (g == 0) begin : g_lsd
      assign blank_c[g] = 1'b0;
    end else begin : g_upper
      assign blank_c[g] = ~|cnt_pad_c[PAD_W-1:4*g];
    end
  end
`endif

  // Assemble next display word
  always_comb begin
    hex_nxt_c = '0;
    for (int k = 0; k < NDIG; k++) begin
      hex_nxt_c[SEG_W*k +: SEG_W] = dig_c[k];
`ifdef HEX_COUNTER_BLANK_LEAD_EN
      if (blank_c[k]) begin
        hex_nxt_c[SEG_W*k +: SEG_W] = SEG_BLANK;
      end
`endif
    end
  end

  // Display register, one cycle behind count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex <= {NDIG{SEG_0}};
    end else begin
      hex <= hex_nxt_c;
    end
  end

endmodule
